// File: rtl/my_fetch_unit.sv
// ============================================================================
// Module   : my_fetch_unit
// Purpose  : Sequential instruction fetch into a 2-entry buffer with redirect.
//            Optional macro FETCH_MISALIGN_TRAP_EN halts on misaligned redirect.
// Revision : 1.0
// ============================================================================
`default_nettype none

module my_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        fetch_err
);

  localparam logic [1:0] C_FULL = 2'(FIFO_DEPTH);

  logic [31:0] fetch_pc_q,  fetch_pc_d;
  logic [1:0]  count_q,     count_d;
  logic [31:0] head_pc_q,   head_pc_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] tail_pc_q,   tail_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d;
  logic        fetch_err_q, fetch_err_d;

  logic        run;
  logic        pop;
  logic        push;
  logic [1:0]  slot;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif

  assign pop  = (count_q != 2'd0) && out_ready;
  assign push = run && !redirect_valid && ((count_q != C_FULL) || pop);
  // Write position after any same-cycle pop has shifted the tail forward.
  assign slot = count_q - {1'b0, pop};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    tail_pc_d   = tail_pc_q;
    tail_inst_d = tail_inst_q;
    fetch_err_d = fetch_err_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    state_d     = state_q;
`endif

    if (redirect_valid) begin
      count_d = 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d     = HALT;
        fetch_err_d = 1'b1;
      end else begin
        state_d     = RUN;
        fetch_err_d = 1'b0;
        fetch_pc_d  = redirect_pc;
      end
`else
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (pop) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
      end
      if (push) begin
        if (slot == 2'd0) begin
          head_pc_d   = fetch_pc_q;
          head_inst_d = imem_rdata;
        end else begin
          tail_pc_d   = fetch_pc_q;
          tail_inst_d = imem_rdata;
        end
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= 2'd0;
      head_pc_q   <= 32'd0;
      head_inst_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      tail_inst_q <= 32'd0;
      fetch_err_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q     <= RUN;
`endif
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      tail_pc_q   <= tail_pc_d;
      tail_inst_q <= tail_inst_d;
      fetch_err_q <= fetch_err_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      state_q     <= state_d;
`endif
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = head_pc_q;
  assign out_inst  = head_inst_q;
  assign fetch_err = fetch_err_q;

endmodule

`default_nettype wire
